// File: rtl/alu_ctrl_issue_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue_if
//   Bundles the ID -> EX issue signals of the ALU control stage.
//   master : the ID-side driver (instruction fields, valid, stall, flush);
//            it observes the issued op and the Busy back-pressure.
//   slave  : the alu_ctrl_issue block itself.
//   Signals:
//     Opcode[5:0]     instruction[31:26]
//     Funct[5:0]      instruction[5:0]
//     InValid         ID presents a valid instruction
//     Stall           downstream hold, freezes the EX register
//     Flush           kill the EX-stage contents
//     ALUControl[3:0] registered ALU op code
//     OutValid        ALUControl carries a valid op this cycle
//     IllegalOp       registered, issued op decoded to the error code
//     Busy            combinational, ID must hold its instruction
// ---------------------------------------------------------------------------
interface alu_ctrl_issue_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       InValid;
  logic       Stall;
  logic       Flush;
  logic [3:0] ALUControl;
  logic       OutValid;
  logic       IllegalOp;
  logic       Busy;

  modport master (
    output Opcode, Funct, InValid, Stall, Flush,
    input  ALUControl, OutValid, IllegalOp, Busy
  );

  modport slave (
    input  Opcode, Funct, InValid, Stall, Flush,
    output ALUControl, OutValid, IllegalOp, Busy
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue
//   Decodes MIPS Opcode/Funct into the 4-bit ALUControl code and registers it
//   into the ID/EX boundary with valid/stall/flush handling. A multiply
//   (code 15) occupies EX for MUL_CYCLES cycles and back-pressures decode.
//   Ports:
//     Clk      rising-edge clock
//     Reset    synchronous, active-high reset
//     alu_bus  alu_ctrl_issue_if.slave (Opcode, Funct, InValid, Stall, Flush
//              in; ALUControl, OutValid, IllegalOp, Busy out)
//   Parameter:
//     MUL_CYCLES  EX occupancy of a multiply in cycles (1..15)
//   Build option:
//     ALU_ROTATE_EN  when defined, R-type Funct 0x04/0x06 decode to rotl (8)
//                    and rotr (9); otherwise both decode to the error code.
// ---------------------------------------------------------------------------
module alu_ctrl_issue #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic            Clk,
  input logic            Reset,
  alu_ctrl_issue_if.slave alu_bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [3:0] CODE_ERR = 4'd14;
  localparam logic [3:0] CODE_MUL = 4'd15;
  // Counter preload; when it reaches 1 the multiply completes on the next edge.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 32'd1);
  localparam logic       MUL_MULTI = (MUL_CYCLES > 32'd1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_q, alu_d;
  logic       valid_q, valid_d;
  logic       ill_q, ill_d;
  logic [3:0] dec_code_s;
  logic       busy_s;
  logic       accept_s;

  // Pure Opcode/Funct -> ALU code decode.
  function automatic logic [3:0] decode_op(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = CODE_ERR;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: code = 4'd2;
          6'h22, 6'h23: code = 4'd6;
          6'h24:        code = 4'd0;
          6'h25:        code = 4'd1;
          6'h26:        code = 4'd3;
          6'h27:        code = 4'd12;
          6'h2A:        code = 4'd7;
          6'h00:        code = 4'd4;
          6'h02:        code = 4'd5;
`ifdef ALU_ROTATE_EN
          6'h04:        code = 4'd8;
          6'h06:        code = 4'd9;
`else
          6'h04, 6'h06: code = CODE_ERR;
`endif
          default:      code = CODE_ERR;
        endcase
      end
      6'h1C: begin
        if (fn == 6'h02) begin
          code = CODE_MUL;
        end else begin
          code = CODE_ERR;
        end
      end
      6'h08, 6'h09, 6'h23, 6'h2B: code = 4'd2;
      6'h0C:        code = 4'd0;
      6'h0D:        code = 4'd1;
      6'h0E:        code = 4'd3;
      6'h0A:        code = 4'd7;
      6'h04, 6'h05: code = 4'd6;
      default:      code = CODE_ERR;
    endcase
    return code;
  endfunction

  // Decode of the instruction currently presented by ID.
  always_comb begin
    dec_code_s = decode_op(alu_bus.Opcode, alu_bus.Funct);
  end

  // Back-pressure and accept qualification.
  always_comb begin
    busy_s   = (state_q == ST_MUL) | alu_bus.Stall;
    accept_s = alu_bus.InValid & ~busy_s & ~alu_bus.Stall & ~alu_bus.Flush;
  end

  // Next-state logic: Flush beats Stall beats Accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alu_d   = alu_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    if (alu_bus.Flush) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (alu_bus.Stall) begin
      // Hold every register.
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            alu_d = dec_code_s;
            ill_d = (dec_code_s == CODE_ERR);
            if ((dec_code_s == CODE_MUL) && MUL_MULTI) begin
              valid_d = 1'b0;
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
            end else begin
              valid_d = 1'b1;
            end
          end else begin
            // Bubble: ALUControl and IllegalOp keep their values.
            valid_d = 1'b0;
          end
        end
        ST_MUL: begin
          if (cnt_q == 4'd1) begin
            valid_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            valid_d = 1'b0;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      alu_q   <= 4'd0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_bus.ALUControl = alu_q;
  assign alu_bus.OutValid   = valid_q;
  assign alu_bus.IllegalOp  = ill_q;
  assign alu_bus.Busy       = busy_s;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;

  localparam int unsigned MULC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_issue_if bus ();

  alu_ctrl_issue #(.MUL_CYCLES(MULC)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .alu_bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference table of legal encodings.
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         any_fn;
    logic [3:0] code;
  } ent_t;
  ent_t tbl[$];

  // Behavioural model state.
  int         m_rem   = 0;     // multiply cycles still owed before completion
  logic       m_valid = 1'b0;
  logic [3:0] m_alu   = 4'd0;
  logic       m_ill   = 1'b0;
  bit         m_known = 1'b1;  // ALUControl is defined (not after a flush)

  function automatic void add_ent(input logic [5:0] op, input logic [5:0] fn,
                                  input bit any_fn, input logic [3:0] code);
    ent_t e;
    e.op = op; e.fn = fn; e.any_fn = any_fn; e.code = code;
    tbl.push_back(e);
  endfunction

  function automatic logic [3:0] lookup(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'd14;
    foreach (tbl[i]) begin
      if (tbl[i].op == op && (tbl[i].any_fn || tbl[i].fn == fn)) r = tbl[i].code;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance for one rising edge using the inputs present at that edge.
  task automatic model_step();
    logic [3:0] c;
    if (rst) begin
      m_valid = 1'b0; m_alu = 4'd0; m_ill = 1'b0; m_rem = 0; m_known = 1'b1;
    end else if (bus.Flush) begin
      m_valid = 1'b0; m_ill = 1'b0; m_rem = 0; m_known = 1'b0;
    end else if (bus.Stall) begin
      m_valid = m_valid;
    end else if (m_rem > 0) begin
      m_rem   = m_rem - 1;
      m_valid = (m_rem == 0);
    end else if (bus.InValid) begin
      c       = lookup(bus.Opcode, bus.Funct);
      m_alu   = c;
      m_known = 1'b1;
      m_ill   = (c == 4'd14);
      if (c == 4'd15 && MULC > 1) begin
        m_valid = 1'b0;
        m_rem   = MULC - 1;
      end else begin
        m_valid = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic v, input logic st, input logic fl);
    rst = r; bus.Opcode = op; bus.Funct = fn;
    bus.InValid = v; bus.Stall = st; bus.Flush = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, bus.Busy}, {31'd0, ((m_rem > 0) | bus.Stall)});
      chk("outvalid", {31'd0, bus.OutValid}, {31'd0, m_valid});
      chk("illegalop", {31'd0, bus.IllegalOp}, {31'd0, m_ill});
      if (m_known) chk("alucontrol", {28'd0, bus.ALUControl}, {28'd0, m_alu});
    end
  end

  initial begin
    logic [5:0] op, fn;
    int k;
    add_ent(6'h00, 6'h20, 1'b0, 4'd2);  add_ent(6'h00, 6'h21, 1'b0, 4'd2);
    add_ent(6'h00, 6'h22, 1'b0, 4'd6);  add_ent(6'h00, 6'h23, 1'b0, 4'd6);
    add_ent(6'h00, 6'h24, 1'b0, 4'd0);  add_ent(6'h00, 6'h25, 1'b0, 4'd1);
    add_ent(6'h00, 6'h26, 1'b0, 4'd3);  add_ent(6'h00, 6'h27, 1'b0, 4'd12);
    add_ent(6'h00, 6'h2A, 1'b0, 4'd7);  add_ent(6'h00, 6'h00, 1'b0, 4'd4);
    add_ent(6'h00, 6'h02, 1'b0, 4'd5);  add_ent(6'h1C, 6'h02, 1'b0, 4'd15);
    add_ent(6'h08, 6'h00, 1'b1, 4'd2);  add_ent(6'h09, 6'h00, 1'b1, 4'd2);
    add_ent(6'h0C, 6'h00, 1'b1, 4'd0);  add_ent(6'h0D, 6'h00, 1'b1, 4'd1);
    add_ent(6'h0E, 6'h00, 1'b1, 4'd3);  add_ent(6'h0A, 6'h00, 1'b1, 4'd7);
    add_ent(6'h23, 6'h00, 1'b1, 4'd2);  add_ent(6'h2B, 6'h00, 1'b1, 4'd2);
    add_ent(6'h04, 6'h00, 1'b1, 4'd6);  add_ent(6'h05, 6'h00, 1'b1, 4'd6);
`ifdef ALU_ROTATE_EN
    add_ent(6'h00, 6'h04, 1'b0, 4'd8);  add_ent(6'h00, 6'h06, 1'b0, 4'd9);
`endif

    // Reset held two cycles.
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_alu", {28'd0, bus.ALUControl}, 32'd0);
    chk("reset_valid", {31'd0, bus.OutValid}, 32'd0);
    chk("reset_ill", {31'd0, bus.IllegalOp}, 32'd0);
    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);

    // First add issues one cycle later.
    step(1'b0, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    chk("add_alu", {28'd0, bus.ALUControl}, 32'd2);
    chk("add_valid", {31'd0, bus.OutValid}, 32'd1);
    chk("add_ill", {31'd0, bus.IllegalOp}, 32'd0);

    // Sweep every listed non-mul encoding back-to-back.
    foreach (tbl[i]) begin
      if (tbl[i].code != 4'd15) begin
        fn = tbl[i].any_fn ? 6'($urandom_range(0, 63)) : tbl[i].fn;
        step(1'b0, tbl[i].op, fn, 1'b1, 1'b0, 1'b0);
        chk("sweep_alu", {28'd0, bus.ALUControl}, {28'd0, tbl[i].code});
        chk("sweep_valid", {31'd0, bus.OutValid}, 32'd1);
        chk("sweep_busy", {31'd0, bus.Busy}, 32'd0);
      end
    end

    // Multiply followed by add: Busy for 3 cycles, done on the 4th.
    step(1'b0, 6'h1C, 6'h02, 1'b1, 1'b0, 1'b0);
    chk("mul_accept_valid", {31'd0, bus.OutValid}, 32'd0);
    chk("mul_accept_alu", {28'd0, bus.ALUControl}, 32'd15);
    for (int c = 0; c < 3; c++) begin
      chk("mul_busy", {31'd0, bus.Busy}, 32'd1);
      step(1'b0, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    end
    chk("mul_done_valid", {31'd0, bus.OutValid}, 32'd1);
    chk("mul_done_alu", {28'd0, bus.ALUControl}, 32'd15);
    chk("mul_done_busy", {31'd0, bus.Busy}, 32'd0);
    step(1'b0, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    chk("after_mul_add", {28'd0, bus.ALUControl}, 32'd2);
    chk("after_mul_valid", {31'd0, bus.OutValid}, 32'd1);

    // Multiply with a two-cycle stall in the middle.
    step(1'b0, 6'h1C, 6'h02, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    chk("stall_alu", {28'd0, bus.ALUControl}, 32'd15);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    chk("stall_alu2", {28'd0, bus.ALUControl}, 32'd15);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("stall_not_done", {31'd0, bus.OutValid}, 32'd0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("stall_done_valid", {31'd0, bus.OutValid}, 32'd1);
    chk("stall_done_alu", {28'd0, bus.ALUControl}, 32'd15);

    // Flush while the multiply counter is at 2.
    step(1'b0, 6'h1C, 6'h02, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'h00, 6'h20, 1'b1, 1'b0, 1'b1);
    chk("flush_valid", {31'd0, bus.OutValid}, 32'd0);
    chk("flush_busy", {31'd0, bus.Busy}, 32'd0);
    chk("flush_ill", {31'd0, bus.IllegalOp}, 32'd0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("flush_no_mul_out", {31'd0, bus.OutValid}, 32'd0);

    // Rotate-right encoding, configuration dependent.
    step(1'b0, 6'h00, 6'h06, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ROTATE_EN
    chk("rotr_alu", {28'd0, bus.ALUControl}, 32'd9);
    chk("rotr_ill", {31'd0, bus.IllegalOp}, 32'd0);
`else
    chk("rotr_alu", {28'd0, bus.ALUControl}, 32'd14);
    chk("rotr_ill", {31'd0, bus.IllegalOp}, 32'd1);
`endif
    chk("rotr_valid", {31'd0, bus.OutValid}, 32'd1);

    // Randomized traffic checked by the every-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 99);
      if (k < 60) begin
        k  = $urandom_range(0, tbl.size() - 1);
        op = tbl[k].op;
        fn = tbl[k].any_fn ? 6'($urandom_range(0, 63)) : tbl[k].fn;
      end else if (k < 75) begin
        op = 6'h00;
        fn = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h06;
      end else if (k < 85) begin
        op = 6'h1C;
        fn = 6'h02;
      end else begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      step(($urandom_range(0, 199) == 0), op, fn,
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 5));
    end

    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
